io_bridge: RTL and testbench

Host-side responder for the CPU's programmed-I/O port: the other end of the `in_signal`/`in_data` and `out_signal`/`out_data` pins. It buffers words supplied by the host (testbench or SoC wrapper) in an input FIFO and presents the head word to the CPU. It also captures words the CPU writes into an output FIFO that the host drains with a valid/ready handshake. It sits beside `cpu` at the top level, between the core and the outside world.

---
 rtl/io_bridge_pkg.sv | 9 +
 rtl/io_fifo.sv | 59 +++++
 rtl/io_bridge.sv | 107 ++++++++++
 tb/tb_io_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants and types for the programmed-I/O bridge.
package io_bridge_pkg;

  localparam int unsigned WORD_W           = 64;
  localparam int unsigned IO_DEPTH_DEFAULT = 8;

  typedef logic [WORD_W-1:0] io_word_t;

endpackage

// File: rtl/io_fifo.sv
// Circular-buffer FIFO with occupancy counter; storage is not reset, only pointers and count.
module io_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Host-side responder for the CPU programmed-I/O port: input and output FIFOs plus strobe edge detect.
// Define IO_BRIDGE_STATUS_EN to expose in_level/out_level occupancy ports.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = IO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_signal,
  output logic [WIDTH-1:0]       in_data,
  input  logic                   out_signal,
  input  logic [WIDTH-1:0]       out_data,
  input  logic                   host_in_valid,
  input  logic [WIDTH-1:0]       host_in_data,
  output logic                   host_in_ready,
  output logic                   host_out_valid,
  output logic [WIDTH-1:0]       host_out_data,
  input  logic                   host_out_ready,
`ifdef IO_BRIDGE_STATUS_EN
  output logic [$clog2(DEPTH):0] in_level,
  output logic [$clog2(DEPTH):0] out_level,
`endif
  output logic                   underflow,
  output logic                   overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             in_q, out_q;
  logic             in_rise, out_rise;
  logic             underflow_q, overflow_q;
  logic [WIDTH-1:0] in_head, out_head;
  logic             in_full, in_empty, out_full, out_empty;
  logic [CW-1:0]    in_count, out_count;
  logic             in_push, out_pop;

  assign in_rise  = in_signal & ~in_q;
  assign out_rise = out_signal & ~out_q;

  assign host_in_ready  = ~in_full;
  assign in_push        = host_in_valid & host_in_ready;
  assign in_data        = in_empty ? '0 : in_head;

  assign host_out_valid = (out_count != '0);
  assign out_pop        = host_out_valid & host_out_ready;
  assign host_out_data  = out_empty ? '0 : out_head;

  assign underflow = underflow_q;
  assign overflow  = overflow_q;

`ifdef IO_BRIDGE_STATUS_EN
  assign in_level  = in_count;
  assign out_level = out_count;
`endif

  io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (in_push),
    .wdata (host_in_data),
    .pop   (in_rise),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (out_rise),
    .wdata (out_data),
    .pop   (out_pop),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q        <= 1'b0;
      out_q       <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      in_q  <= in_signal;
      out_q <= out_signal;
      if (in_rise && (in_count == '0)) begin
        underflow_q <= 1'b1;
      end
      // A write into a full FIFO survives only if the host drains a word that same cycle.
      if (out_rise && out_full && !out_pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: directed scenarios plus random traffic against a queue-based model.
module tb_io_bridge;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_signal = 1'b0;
  logic [WIDTH-1:0] in_data;
  logic             out_signal = 1'b0;
  logic [WIDTH-1:0] out_data = '0;
  logic             host_in_valid = 1'b0;
  logic [WIDTH-1:0] host_in_data = '0;
  logic             host_in_ready;
  logic             host_out_valid;
  logic [WIDTH-1:0] host_out_data;
  logic             host_out_ready = 1'b0;
  logic             underflow, overflow;
`ifdef IO_BRIDGE_STATUS_EN
  logic [$clog2(DEPTH):0] in_level, out_level;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_inq[$];
  logic [WIDTH-1:0] m_outq[$];
  bit               m_in_prev, m_out_prev, m_uf, m_of;

  always #5 clk = ~clk;

  io_bridge #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_signal      (in_signal),
    .in_data        (in_data),
    .out_signal     (out_signal),
    .out_data       (out_data),
    .host_in_valid  (host_in_valid),
    .host_in_data   (host_in_data),
    .host_in_ready  (host_in_ready),
    .host_out_valid (host_out_valid),
    .host_out_data  (host_out_data),
    .host_out_ready (host_out_ready),
`ifdef IO_BRIDGE_STATUS_EN
    .in_level       (in_level),
    .out_level      (out_level),
`endif
    .underflow      (underflow),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("in_data", in_data, (m_inq.size() > 0) ? m_inq[0] : 64'h0);
    check("host_in_ready", 64'(host_in_ready), 64'(m_inq.size() < DEPTH));
    check("host_out_valid", 64'(host_out_valid), 64'(m_outq.size() > 0));
    check("host_out_data", host_out_data, (m_outq.size() > 0) ? m_outq[0] : 64'h0);
    check("underflow", 64'(underflow), 64'(m_uf));
    check("overflow", 64'(overflow), 64'(m_of));
`ifdef IO_BRIDGE_STATUS_EN
    check("in_level", 64'(in_level), 64'(m_inq.size()));
    check("out_level", 64'(out_level), 64'(m_outq.size()));
`endif
  endtask

  // Inputs are driven at posedge+1; outputs compared at posedge+3; model advances on posedge.
  task automatic cycle();
    bit in_rise, out_rise, in_push, in_pop, out_push, out_pop;
    #2;
    check_model();
    @(posedge clk);
    in_rise  = in_signal && !m_in_prev;
    out_rise = out_signal && !m_out_prev;
    in_push  = host_in_valid && (m_inq.size() < DEPTH);
    in_pop   = in_rise && (m_inq.size() > 0);
    if (in_rise && m_inq.size() == 0) m_uf = 1'b1;
    out_pop  = host_out_ready && (m_outq.size() > 0);
    out_push = out_rise && ((m_outq.size() < DEPTH) || out_pop);
    if (out_rise && !out_push) m_of = 1'b1;
    if (in_pop) void'(m_inq.pop_front());
    if (in_push) m_inq.push_back(host_in_data);
    if (out_pop) void'(m_outq.pop_front());
    if (out_push) m_outq.push_back(out_data);
    m_in_prev  = in_signal;
    m_out_prev = out_signal;
    #1;
  endtask

  task automatic clear_inputs();
    in_signal      = 1'b0;
    out_signal     = 1'b0;
    out_data       = '0;
    host_in_valid  = 1'b0;
    host_in_data   = '0;
    host_out_ready = 1'b0;
  endtask

  // Assert reset mid-cycle and check that outputs drop immediately, then release away from the edge.
  task automatic do_reset();
    #1;
    reset = 1'b0;
    clear_inputs();
    m_inq.delete();
    m_outq.delete();
    m_in_prev  = 1'b0;
    m_out_prev = 1'b0;
    m_uf       = 1'b0;
    m_of       = 1'b0;
    #1;
    check("rst in_data", in_data, 64'h0);
    check("rst host_in_ready", 64'(host_in_ready), 64'h1);
    check("rst host_out_valid", 64'(host_out_valid), 64'h0);
    check("rst host_out_data", host_out_data, 64'h0);
    check("rst underflow", 64'(underflow), 64'h0);
    check("rst overflow", 64'(overflow), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input logic [WIDTH-1:0] d);
    host_in_valid = 1'b1;
    host_in_data  = d;
    cycle();
    host_in_valid = 1'b0;
  endtask

  task automatic pulse_in();
    in_signal = 1'b1;
    cycle();
    in_signal = 1'b0;
    cycle();
  endtask

  task automatic pulse_out(input logic [WIDTH-1:0] d);
    out_signal = 1'b1;
    out_data   = d;
    cycle();
    out_signal = 1'b0;
    cycle();
  endtask

  initial begin
    #3;
    check("por in_data", in_data, 64'h0);
    check("por host_in_ready", 64'(host_in_ready), 64'h1);
    check("por host_out_valid", 64'(host_out_valid), 64'h0);
    @(posedge clk);
    do_reset();

    // Two words read back in order, third read underflows.
    host_push(64'h11);
    host_push(64'h22);
    check("read1 head", in_data, 64'h11);
    pulse_in();
    check("read2 head", in_data, 64'h22);
    pulse_in();
    pulse_in();
    check("read3 empty", in_data, 64'h0);
    check("read3 underflow", 64'(underflow), 64'h1);

    // Held strobe pops only once.
    do_reset();
    host_push(64'hA);
    host_push(64'hB);
    in_signal = 1'b1;
    repeat (4) cycle();
    in_signal = 1'b0;
    cycle();
    check("held strobe head", in_data, 64'hB);

    // Fill input FIFO; extra offer refused; one pop reopens.
    do_reset();
    for (int i = 1; i <= 8; i++) host_push(64'(i));
    check("in full ready", 64'(host_in_ready), 64'h0);
    host_push(64'h99);
    pulse_in();
    check("in reopen ready", 64'(host_in_ready), 64'h1);
    check("in head after pop", in_data, 64'h2);
    for (int i = 2; i <= 8; i++) pulse_in();
    check("in drained", in_data, 64'h0);
    check("in no underflow", 64'(underflow), 64'h0);

    // Output overflow with host stalled, then ordered drain.
    do_reset();
    for (int i = 1; i <= 9; i++) pulse_out(64'(i));
    check("out overflow", 64'(overflow), 64'h1);
    host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("out drain", host_out_data, 64'(i));
      cycle();
    end
    check("out drained", 64'(host_out_valid), 64'h0);

    // Write into full FIFO while host drains is accepted.
    do_reset();
    for (int i = 1; i <= 8; i++) pulse_out(64'(i));
    host_out_ready = 1'b1;
    out_signal     = 1'b1;
    out_data       = 64'h55;
    cycle();
    out_signal = 1'b0;
    check("full+drain no overflow", 64'(overflow), 64'h0);
    for (int i = 2; i <= 8; i++) begin
      check("full+drain order", host_out_data, 64'(i));
      cycle();
    end
    check("full+drain last", host_out_data, 64'h55);
    cycle();
    check("full+drain overflow", 64'(overflow), 64'h0);

    // Mid-stream reset with both FIFOs partly full.
    do_reset();
    host_push(64'h1234);
    host_push(64'h5678);
    pulse_out(64'h9abc);
    pulse_out(64'hdef0);
    check("pre-reset valid", 64'(host_out_valid), 64'h1);
    do_reset();
    cycle();
    check("post-reset in_data", in_data, 64'h0);
    check("post-reset out_valid", 64'(host_out_valid), 64'h0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      host_in_valid  = ($urandom_range(0, 99) < 55);
      host_in_data   = {$urandom, $urandom};
      in_signal      = ($urandom_range(0, 99) < 40);
      out_signal     = ($urandom_range(0, 99) < 45);
      out_data       = {$urandom, $urandom};
      host_out_ready = ($urandom_range(0, 99) < (n < 300 ? 30 : 70));
      cycle();
      if (n == 400) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
